// File: rtl/instr_sequencer.sv
// Instruction sequencer: host-loaded program memory stepped through a fetch/execute FSM,
// driving one-hot control strobes, a base address and run status to the array datapath.
module instr_sequencer #(
  parameter int unsigned IMEM_DEPTH     = 16,
  parameter int unsigned PC_W           = $clog2(IMEM_DEPTH),
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned COMPUTE_CYCLES = 4,
  parameter int unsigned CNT_W          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              start,
  output logic [ADDR_W-1:0] base_address,
  output logic              load_weight,
  output logic              load_input,
  output logic              valid,
  output logic              store,
  output logic              ext,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CYC_W = $clog2(COMPUTE_CYCLES + 1);
  localparam logic [CYC_W-1:0] CycLast = CYC_W'(COMPUTE_CYCLES - 1);
  localparam logic [PC_W-1:0]  PcLast  = PC_W'(IMEM_DEPTH - 1);

  localparam logic [2:0] OpHalt       = 3'b000;
  localparam logic [2:0] OpLoadAddr   = 3'b001;
  localparam logic [2:0] OpLoadWeight = 3'b010;
  localparam logic [2:0] OpLoadInputs = 3'b011;
  localparam logic [2:0] OpCompute    = 3'b100;
  localparam logic [2:0] OpStore      = 3'b101;
  localparam logic [2:0] OpJnz        = 3'b110;
  localparam logic [2:0] OpMisc       = 3'b111;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

  state_e           state;
  logic [PC_W-1:0]  pc;
  logic [7:0]       instr;
  logic [CNT_W-1:0] loop_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [7:0]       imem [IMEM_DEPTH];
  logic [7:0]       imem_rd;
  logic [2:0]       op;
  logic [2:0]       fetch_op;

  assign imem_rd  = imem[pc];
  assign op       = instr[7:5];
  assign fetch_op = imem_rd[7:5];
  assign busy     = (state == StFetch) || (state == StExec);

  // Program memory is only writable while the sequencer is parked.
  always_ff @(posedge clk) begin
    if (prog_we && ((state == StIdle) || (state == StDone))) begin
      imem[prog_addr] <= prog_data;
    end
  end

  // Strobes are registered on the FETCH->EXEC edge so they are high for the whole EXEC window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      pc           <= '0;
      instr        <= '0;
      loop_cnt     <= '0;
      cyc_cnt      <= '0;
      base_address <= '0;
      load_weight  <= 1'b0;
      load_input   <= 1'b0;
      valid        <= 1'b0;
      store        <= 1'b0;
      ext          <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state    <= StFetch;
            pc       <= '0;
            loop_cnt <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        StFetch: begin
          instr       <= imem_rd;
          state       <= StExec;
          cyc_cnt     <= '0;
          load_weight <= (fetch_op == OpLoadWeight);
          load_input  <= (fetch_op == OpLoadInputs);
          valid       <= (fetch_op == OpCompute);
          store       <= (fetch_op == OpStore);
          ext         <= (fetch_op == OpMisc) && imem_rd[4];
        end
        StExec: begin
          load_weight <= 1'b0;
          load_input  <= 1'b0;
          store       <= 1'b0;
          ext         <= 1'b0;
          if ((op == OpCompute) && (cyc_cnt != CycLast)) begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end else begin
            valid <= 1'b0;
            if (op == OpLoadAddr) begin
              base_address <= instr[ADDR_W-1:0];
            end
            if ((op == OpMisc) && !instr[4]) begin
              loop_cnt <= instr[CNT_W-1:0];
            end
            if (op == OpHalt) begin
              state <= StDone;
              done  <= 1'b1;
            end else if ((op == OpJnz) && (loop_cnt != '0)) begin
              loop_cnt <= loop_cnt - CNT_W'(1);
              pc       <= instr[PC_W-1:0];
              state    <= StFetch;
            end else if (pc == PcLast) begin
              // Falling off the end of memory terminates the run rather than wrapping.
              state <= StDone;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              pc    <= pc + PC_W'(1);
              state <= StFetch;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
